ifetch: RTL and testbench
=========================

# ifetch

Instruction-fetch stage plus IF/ID pipeline register of the five-stage miniRV pipeline. It holds the PC, drives the combinational instruction ROM, and registers the fetched instruction into `if_id_inst` for the decode stage. It applies load-use stalls and taken-branch/jump redirects from EX, and inserts NOP bubbles on flush. It also maintains fetch/bubble performance counters and a sticky misaligned-target flag.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, 32'h0000_0013: encoding injected into IF/ID on flush/reset (`addi x0,x0,0`).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  load-use hazard from the hazard unit; hold PC and IF/ID.
- `redirect`  in  1  EX resolved a taken branch, `jal` or `jalr`.
- `redirect_pc`  in  32  target PC, valid when `redirect`=1.
- `irom_inst`  in  32  instruction word from the ROM, combinational on `irom_addr`.
- `irom_addr`  out  32  current PC (`pc_q`), driven to the ROM.
- `if_id_inst`  out  32  registered instruction to decode.
- `if_id_pc`  out  32  PC of `if_id_inst`.
- `if_id_pc4`  out  32  `if_id_pc`+4, used as the link value for `jal`/`jalr`.
- `if_id_valid`  out  1  0 when IF/ID holds an injected bubble.
- `misalign`  out  1  sticky; set when a `redirect_pc` had bits[1:0]≠0.
- `fetch_cnt`  out  32  count of instructions accepted into IF/ID.
- `bubble_cnt`  out  32  count of cycles IF/ID was loaded with a bubble.

## Operation
- Per-cycle priority: `rst` > `redirect` > `stall` > normal fetch.
- **Reset:**
  - `pc_q`=RESET_PC.
  - `if_id_inst`=NOP_INST, `if_id_pc`=0, `if_id_pc4`=4, `if_id_valid`=0.
  - `misalign`=0, both counters=0.
- **Redirect:**
  - `pc_q` <= {`redirect_pc`[31:2],2'b00}.
  - IF/ID <= NOP_INST with `valid`=0; `if_id_pc`/`if_id_pc4` are loaded with the current `pc_q`/`pc_q`+4 (don't-care).
  - `bubble_cnt`+1.
  - If `redirect_pc`[1:0]≠0, set `misalign`. It stays set until `rst`.
  - EX/ID flush of the decoded instruction is owned by the hazard unit, not by this block.
- **Stall (no redirect):**
  - `pc_q`, all IF/ID fields and both counters hold.
  - The ROM is re-read at the same address.
- **Normal:**
  - `pc_q` <= `pc_q`+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - IF/ID <= {`irom_inst`, `pc_q`, `pc_q`+4, valid=1}.
  - `fetch_cnt`+1.
- Arithmetic rules:
  - All PC arithmetic is unsigned 32-bit.
  - Counters wrap silently at 2^32.
- `stall`=1 together with `redirect`=1: redirect wins, because the stalled instruction is on the squashed path.

## Timing
- No combinational path from `stall`/`redirect` to `irom_addr`; `irom_addr` = `pc_q` always.
- Fetch latency: an instruction at PC p is visible on `if_id_inst` one cycle after `pc_q`=p, provided that cycle is neither stalled nor redirected.
- Redirect asserted in cycle t:
  - t+1: `pc_q`=target and `if_id_valid`=0.
  - t+2: `if_id_inst`=ROM[target] and `valid`=1, assuming no stall.
- Branch penalty is 2 bubbles total: this block contributes one, the hazard unit's ID flush the other.
- Stall for N cycles: outputs constant for N cycles; fetch resumes on the first cycle with `stall`=0.
- `rst` asserted mid-stall or mid-redirect: reset state at the next edge; in-flight redirect is dropped.

## Structure
- Shared package `defines.vh` gains:
  - `RESET_PC` and `NOP_INST` constants.
  - the PC increment constant (4).
- Sub-module `pc_reg`: PC register with next-PC mux (+4 / aligned redirect / hold). The IF/ID register and counters stay in the top.

## Test plan
- **Reset then run:** `rst` for 2 cycles, ROM[0]=32'h0010_0093, ROM[4]=32'h0020_0113 → cycle 1 after release `if_id_inst`=32'h0010_0093, `if_id_pc`=0, `if_id_pc4`=4, valid=1; next cycle `if_id_pc`=4; `fetch_cnt`=2.
- **Stall:** at `pc_q`=8, `stall` for 3 cycles → `irom_addr`=8 and IF/ID unchanged for 3 cycles, `fetch_cnt` unchanged; then `if_id_pc`=8.
- **Redirect:** `redirect`=1, `redirect_pc`=32'h40 while `pc_q`=0x10 → next cycle `pc_q`=0x40, `if_id_inst`=32'h0000_0013, valid=0, `bubble_cnt`=1; following cycle `if_id_pc`=0x40.
- **Stall+redirect same cycle:** `stall`=`redirect`=1, `redirect_pc`=32'h80 → `pc_q`=0x80 and a bubble is inserted; no hold occurs.
- **Misaligned target:** `redirect_pc`=32'h0000_0102 → `pc_q`=0x100, `misalign`=1; it stays 1 through 10 further cycles and clears only after `rst`.
- **Wrap and mid-flight reset:** start `pc_q`=32'hFFFF_FFFC → next `pc_q`=0. Asserting `rst` with `redirect`=1 → `pc_q`=RESET_PC and counters=0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared constants and helpers for the miniRV instruction-fetch stage.
package ifetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] PC_INC   = 32'd4;

    // Word-align a jump/branch target by dropping the low two bits.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// Program counter register with next-PC select: aligned redirect, hold, or +4.
module ifetch_pc_reg
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next-PC select; redirect outranks stall because the stalled fetch is squashed.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i;
        end else if (!stall_i) begin
            pc_d = pc_q + PC_INC;
        end
    end

    // PC state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch plus IF/ID pipeline register, bubble injection on redirect,
// fetch/bubble counters and a sticky misaligned-target flag.
module ifetch
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] irom_inst,
    output logic [31:0] irom_addr,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
);

    logic [31:0] pc;
    logic [31:0] inst_q,  inst_d;
    logic [31:0] idpc_q,  idpc_d;
    logic [31:0] idpc4_q, idpc4_d;
    logic        valid_q, valid_d;
    logic        mis_q,   mis_d;
    logic [31:0] fcnt_q,  fcnt_d;
    logic [31:0] bcnt_q,  bcnt_d;

    ifetch_pc_reg u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .redirect_i (redirect),
        .target_i   (align_pc(redirect_pc)),
        .pc_o       (pc)
    );

    // IF/ID next-state: bubble on redirect, hold on stall, capture ROM word otherwise.
    always_comb begin
        inst_d  = inst_q;
        idpc_d  = idpc_q;
        idpc4_d = idpc4_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        fcnt_d  = fcnt_q;
        bcnt_d  = bcnt_q;
        if (redirect) begin
            inst_d  = NOP_INST;
            idpc_d  = pc;
            idpc4_d = pc + PC_INC;
            valid_d = 1'b0;
            bcnt_d  = bcnt_q + 32'd1;
            if (is_misaligned(redirect_pc)) begin
                mis_d = 1'b1;
            end
        end else if (!stall) begin
            inst_d  = irom_inst;
            idpc_d  = pc;
            idpc4_d = pc + PC_INC;
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + 32'd1;
        end
    end

    // IF/ID, flag and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q  <= NOP_INST;
            idpc_q  <= RESET_PC;
            idpc4_q <= RESET_PC + PC_INC;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            fcnt_q  <= 32'd0;
            bcnt_q  <= 32'd0;
        end else begin
            inst_q  <= inst_d;
            idpc_q  <= idpc_d;
            idpc4_q <= idpc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            fcnt_q  <= fcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign irom_addr   = pc;
    assign if_id_inst  = inst_q;
    assign if_id_pc    = idpc_q;
    assign if_id_pc4   = idpc4_q;
    assign if_id_valid = valid_q;
    assign misalign    = mis_q;
    assign fetch_cnt   = fcnt_q;
    assign bubble_cnt  = bcnt_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed-vector bench for ifetch with a queue-based scoreboard.
module tb_ifetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] idpc;
        logic [31:0] idpc4;
        logic        valid;
        logic        mis;
        logic [31:0] fcnt;
        logic [31:0] bcnt;
        logic        chk_idpc;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] irom_inst;
    logic [31:0] irom_addr;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        if (a == 32'h4) return 32'h0020_0113;
        return {a[23:0], 8'h33};
    endfunction

    assign irom_inst = rom(irom_addr);

    ifetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irom_inst   (irom_inst),
        .irom_addr   (irom_addr),
        .if_id_inst  (if_id_inst),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .misalign    (misalign),
        .fetch_cnt   (fetch_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL vec%0d %s: got %h expected %h", n_vec, name, act, req);
        end
    endtask

    // Monitor: after each edge, compare outputs against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("irom_addr", irom_addr, e.pc);
            chk("if_id_inst", if_id_inst, e.inst);
            chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
            chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
            chk("fetch_cnt", fetch_cnt, e.fcnt);
            chk("bubble_cnt", bubble_cnt, e.bcnt);
            if (e.chk_idpc) begin
                chk("if_id_pc", if_id_pc, e.idpc);
                chk("if_id_pc4", if_id_pc4, e.idpc4);
            end
            n_vec++;
        end
    end

    // Apply one cycle of inputs and queue the state expected after the next edge.
    task automatic vec(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] idpc,
                       input logic v, input logic m, input logic [31:0] f, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        e.pc = pc; e.inst = inst; e.idpc = idpc; e.idpc4 = idpc + 32'd4;
        e.valid = v; e.mis = m; e.fcnt = f; e.bcnt = b;
        e.chk_idpc = v | r;
        exp_q.push_back(e);
    endtask

    initial begin
        // reset for two cycles
        vec(1,0,0,0,          32'h0,  NOP,          32'h0, 0,0, 0,0);
        vec(1,0,0,0,          32'h0,  NOP,          32'h0, 0,0, 0,0);
        // run
        vec(0,0,0,0,          32'h4,  32'h0010_0093, 32'h0, 1,0, 1,0);
        vec(0,0,0,0,          32'h8,  32'h0020_0113, 32'h4, 1,0, 2,0);
        // stall 3 cycles at pc 8
        for (int i = 0; i < 3; i++)
            vec(0,1,0,0,      32'h8,  32'h0020_0113, 32'h4, 1,0, 2,0);
        vec(0,0,0,0,          32'hC,  rom(32'h8),    32'h8, 1,0, 3,0);
        vec(0,0,0,0,          32'h10, rom(32'hC),    32'hC, 1,0, 4,0);
        // redirect to 0x40 while pc is 0x10
        vec(0,0,1,32'h40,     32'h40, NOP,           32'h0, 0,0, 4,1);
        vec(0,0,0,0,          32'h44, rom(32'h40),   32'h40,1,0, 5,1);
        // stall and redirect together
        vec(0,1,1,32'h80,     32'h80, NOP,           32'h0, 0,0, 5,2);
        vec(0,0,0,0,          32'h84, rom(32'h80),   32'h80,1,0, 6,2);
        // misaligned target
        vec(0,0,1,32'h102,    32'h100,NOP,           32'h0, 0,1, 6,3);
        for (int k = 0; k < 10; k++)
            vec(0,0,0,0, 32'h104 + 32'(4*k), rom(32'h100 + 32'(4*k)),
                32'h100 + 32'(4*k), 1,1, 32'(7+k), 3);
        // wrap through the top of the address space
        vec(0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP, 32'h0, 0,1, 16,4);
        vec(0,0,0,0,          32'h0,  rom(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1,1, 17,4);
        vec(0,0,0,0,          32'h4,  32'h0010_0093, 32'h0, 1,1, 18,4);
        // reset together with a redirect: redirect dropped, everything cleared
        vec(1,0,1,32'h200,    32'h0,  NOP,           32'h0, 0,0, 0,0);
        vec(0,0,0,0,          32'h4,  32'h0010_0093, 32'h0, 1,0, 1,0);
        @(negedge clk);
        rst = 0; stall = 0; redirect = 0;
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
